// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM states, word type.
// Latency: none (types only).
// Backpressure: none (types only).
package cpu_types_pkg;

    // RAM-side status as reported on ramstate
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        INSTR = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } arb_state_t;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/memory_arbiter_access_timer.sv
// Wait counter for one RAM access: clear / increment / saturate at 255, compared against TIMEOUT.
// Latency: count updates on the clock edge; expire is decoded from the registered count.
// Backpressure: none; the owner decides when to clear and increment.
// Ports: CLK, nRst (async active-low), clr, inc in; expire out (count has reached TIMEOUT-1,
//        i.e. the current cycle is the TIMEOUT-th consecutive cycle in the access state).
module access_timer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] MAXV = '1;

    logic [TIMER_W-1:0] count;

    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAXV)) begin
            count <= count + 1'b1;
        end
    end

    // count is 0 in the first access cycle, so count == TIMEOUT-1 marks the
    // TIMEOUT-th waiting cycle; the FSM leaves on the edge that ends it.
    assign expire = (count >= LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises data and instruction accesses, data has priority at IDLE.
// Latency: request in IDLE cycle 0 -> RAM enables in cycle 1 -> hit pulse in cycle 2 (+1 per non-ACCESS cycle).
// Backpressure: requests are only sampled in IDLE; a sticky error (RAM ERROR or timeout) halts until nRst.
// Ports: CLK, nRst; iREN/iaddr -> iload/ihit; dREN/dWEN/daddr/dstore -> dload/dhit;
//        ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramstate <- RAM; err sticky error flag.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRst,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    arb_state_t  state_q, state_d;
    ramstate_t   rs;

    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic              wr_q;      // latched access is a write
    logic              tgt_i_q;   // latched access belongs to the instruction side
    logic [WORD_W-1:0] iload_q;
    logic [WORD_W-1:0] dload_q;

    logic in_access;
    logic dreq;
    logic expire;

    assign rs        = ramstate_t'(ramstate);
    assign in_access = (state_q == DATA) || (state_q == INSTR);
    assign dreq      = dREN | dWEN;

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .nRst   (nRst),
        .clr    (!in_access),
        .inc    (in_access),
        .expire (expire)
    );

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq) begin
                    state_d = DATA;
                end else if (iREN) begin
                    state_d = INSTR;
                end
            end
            DATA, INSTR: begin
                // ACCESS wins over a simultaneous timeout: the data did arrive.
                if (rs == ACCESS) begin
                    state_d = RESP;
                end else if ((rs == ERROR) || expire) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request latch and load capture ----------------
    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            tgt_i_q <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            // Inputs are only looked at when leaving IDLE; the RAM side is then
            // driven purely from these registers so mid-access input changes are ignored.
            if ((state_q == IDLE) && (state_d != IDLE)) begin
                addr_q  <= dreq ? daddr : iaddr;
                store_q <= dreq ? dstore : '0;
                wr_q    <= dWEN;          // dREN+dWEN together is a write
                tgt_i_q <= !dreq;
            end
            if (in_access && (rs == ACCESS)) begin
                if (tgt_i_q) begin
                    iload_q <= ramload;
                end else if (!wr_q) begin
                    dload_q <= ramload;
                end
            end
        end
    end

    // ---------------- outputs: decoded from state and latched registers ----------------
    assign ramREN   = (state_q == INSTR) || ((state_q == DATA) && !wr_q);
    assign ramWEN   = (state_q == DATA) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ihit     = (state_q == RESP) && tgt_i_q;
    assign dhit     = (state_q == RESP) && !tgt_i_q;
    assign err      = (state_q == ERR);
    assign iload    = iload_q;
    assign dload    = dload_q;

endmodule
